// File: rtl/inv_pkg.sv
// ---------------------------------------------------------------------------
// inv_pkg
// Shared definitions for the matrix-inverter fixed-point converter.
//   - state_t        : converter FSM states
//   - FRAC_BITS_DEF  : default number of fractional output bits (Q16.16)
//   - ELEMS_DEF      : default number of elements per 5x5 matrix
//   - IDX_W          : width of element indices
//   - Q_POS_MAX/Q_NEG_MAX : saturation limits of the signed 32-bit result
//   - absVal()       : 32-bit two's-complement magnitude (-2^31 -> 2^31)
// ---------------------------------------------------------------------------
package inv_pkg;

    localparam int FRAC_BITS_DEF = 16;
    localparam int ELEMS_DEF     = 25;
    localparam int IDX_W         = 5;

    localparam logic [31:0] Q_POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_NEG_MAX = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DIV,
        FIX,
        OUT,
        FIN
    } state_t;

    // Magnitude is returned unsigned, so the most negative input maps to
    // 2^31 without overflow.
    function automatic logic [31:0] absVal(input logic [31:0] v);
        absVal = v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_seq_unsigned.sv
// ---------------------------------------------------------------------------
// div_seq_unsigned
// Restoring unsigned divider, one quotient bit per step, MSB first.
// The dividend is left-aligned in an ITERS-wide shift register, so running
// more iterations than DVD_W appends zero bits below the dividend LSB (used
// to produce an extra rounding bit).
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   load_i         : capture dividend/divisor and clear the iteration count
//   step_i         : perform one restoring iteration
//   dividend_i     : DVD_W-bit unsigned dividend
//   divisor_i      : DVS_W-bit unsigned divisor
//   quotient_o     : ITERS-bit quotient, valid after ITERS steps
//   done_o         : high during the step that produces the final quotient bit
// ---------------------------------------------------------------------------
module div_seq_unsigned #(
    parameter int DVD_W = 48,
    parameter int DVS_W = 32,
    parameter int ITERS = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [ITERS-1:0] quotient_o,
    output logic             done_o
);

    logic [ITERS-1:0] shift_q;
    logic [DVS_W-1:0] rem_q;
    logic [DVS_W-1:0] divisor_q;
    logic [5:0]       cnt_q;

    logic [DVS_W:0]   trial;
    logic             fits;
    logic [DVS_W-1:0] diff;

    // Trial subtraction: remainder shifted left with the next dividend bit.
    // When the divisor fits, the difference is below the divisor, so the
    // low DVS_W bits of the modular subtraction are exact.
    always_comb begin
        trial = {rem_q, shift_q[ITERS-1]};
        fits  = (trial >= {1'b0, divisor_q});
        diff  = trial[DVS_W-1:0] - divisor_q;
    end

    // Quotient bits are shifted in from the bottom as dividend bits leave
    // the top, so after ITERS steps the register holds only the quotient.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else if (load_i) begin
            shift_q   <= ITERS'(dividend_i) << (ITERS - DVD_W);
            rem_q     <= '0;
            divisor_q <= divisor_i;
            cnt_q     <= '0;
        end else if (step_i) begin
            rem_q   <= fits ? diff : trial[DVS_W-1:0];
            shift_q <= {shift_q[ITERS-2:0], fits};
            cnt_q   <= cnt_q + 6'd1;
        end
    end

    assign quotient_o = shift_q;
    assign done_o     = step_i && (cnt_q == 6'(ITERS - 1));

endmodule

// File: rtl/inv_fixpt_converter.sv
// ---------------------------------------------------------------------------
// inv_fixpt_converter
// Walks the 25 rational results of the 5x5 inverter and converts each
// numerator/denominator pair into a signed Q16.16 value, one element at a
// time, delivering results on a valid/ready stream.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start               : one-cycle request, honoured only when idle
//   elem_idx            : index of the pair the upstream mux must present
//   num_in, den_in      : signed numerator/denominator for elem_idx
//   q_out, q_idx        : converted result and its index
//   q_valid, q_ready    : output stream handshake
//   busy, done          : activity indicator, end-of-matrix pulse
//   dz_flag, sat_flag   : sticky zero-denominator / saturation flags
// Build option:
//   INV_FIXPT_ROUND_EN  : one extra divide iteration and round-half-away-
//                         from-zero instead of truncation toward zero.
// ---------------------------------------------------------------------------
module inv_fixpt_converter
    import inv_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ELEMS     = ELEMS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] elem_idx,
    input  logic [31:0]      num_in,
    input  logic [31:0]      den_in,
    output logic [31:0]      q_out,
    output logic [IDX_W-1:0] q_idx,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             done,
    output logic             dz_flag,
    output logic             sat_flag
);

    localparam int DVD_W = 32 + FRAC_BITS;
`ifdef INV_FIXPT_ROUND_EN
    localparam int DIV_ITERS = DVD_W + 1;
`else
    localparam int DIV_ITERS = DVD_W;
`endif
    // One spare bit so the rounding increment can never wrap.
    localparam int MAG_W = DVD_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0] elemIdx_q;
    logic [31:0]      qOut_q;
    logic [IDX_W-1:0] qIdx_q;
    logic             numNeg_q;
    logic             denNeg_q;
    logic             divZero_q;
    logic             dzFlag_q;
    logic             satFlag_q;

    logic                 divLoad;
    logic                 divStep;
    logic                 divDone;
    logic [DIV_ITERS-1:0] quotient;
    logic                 handshake;
    logic                 lastElem;

    logic [MAG_W-1:0] magRaw;
    logic [MAG_W-1:0] mag;
    logic             resNeg;
    logic [31:0]      fixVal;
    logic             fixSat;

    div_seq_unsigned #(
        .DVD_W (DVD_W),
        .DVS_W (32),
        .ITERS (DIV_ITERS)
    ) uDiv (
        .clk        (clk),
        .reset      (reset),
        .load_i     (divLoad),
        .step_i     (divStep),
        .dividend_i ({absVal(num_in), {FRAC_BITS{1'b0}}}),
        .divisor_i  (absVal(den_in)),
        .quotient_o (quotient),
        .done_o     (divDone)
    );

    assign handshake = (state_q == OUT) && q_ready;
    assign lastElem  = (elemIdx_q == LAST_IDX);

    // Sign, rounding and saturation for the FIX cycle. A zero denominator
    // bypasses the divider with a forced full-scale magnitude. The most
    // negative value is representable, hence the asymmetric limits.
    always_comb begin
`ifdef INV_FIXPT_ROUND_EN
        magRaw = MAG_W'(quotient[DIV_ITERS-1:1]) + MAG_W'(quotient[0]);
`else
        magRaw = MAG_W'(quotient);
`endif
        mag    = divZero_q ? MAG_W'(Q_POS_MAX) : magRaw;
        resNeg = (numNeg_q ^ denNeg_q) && (mag != '0);
        fixSat = 1'b0;
        if (!resNeg && (mag > MAG_W'(Q_POS_MAX))) begin
            fixVal = Q_POS_MAX;
            fixSat = 1'b1;
        end else if (resNeg && (mag > MAG_W'(Q_NEG_MAX))) begin
            fixVal = Q_NEG_MAX;
            fixSat = 1'b1;
        end else if (resNeg) begin
            fixVal = ~mag[31:0] + 32'd1;
        end else begin
            fixVal = mag[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero denominator skips the divider entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = (den_in == 32'd0) ? FIX : DIV;
            DIV:     if (divDone) state_d = FIX;
            FIX:     state_d = OUT;
            OUT:     if (handshake) state_d = lastElem ? FIN : FETCH;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and divider controls decoded from the current state.
    always_comb begin
        q_valid = (state_q == OUT);
        busy    = (state_q != IDLE);
        done    = (state_q == FIN);
        divLoad = (state_q == FETCH);
        divStep = (state_q == DIV);
    end

    // Datapath registers. elem_idx only moves on the exit edge of OUT so
    // the upstream mux has a full cycle to settle before the next FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elemIdx_q <= '0;
            qOut_q    <= '0;
            qIdx_q    <= '0;
            numNeg_q  <= 1'b0;
            denNeg_q  <= 1'b0;
            divZero_q <= 1'b0;
            dzFlag_q  <= 1'b0;
            satFlag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        elemIdx_q <= '0;
                        dzFlag_q  <= 1'b0;
                        satFlag_q <= 1'b0;
                    end
                end
                FETCH: begin
                    numNeg_q  <= num_in[31];
                    denNeg_q  <= den_in[31];
                    divZero_q <= (den_in == 32'd0);
                    if (den_in == 32'd0) begin
                        dzFlag_q <= 1'b1;
                    end
                end
                FIX: begin
                    qOut_q <= fixVal;
                    qIdx_q <= elemIdx_q;
                    if (fixSat) begin
                        satFlag_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (handshake && !lastElem) begin
                        elemIdx_q <= elemIdx_q + IDX_W'(1);
                    end
                end
                FIN: begin
                    elemIdx_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign elem_idx = elemIdx_q;
    assign q_out    = qOut_q;
    assign q_idx    = qIdx_q;
    assign dz_flag  = dzFlag_q;
    assign sat_flag = satFlag_q;

endmodule

// File: tb/tb_inv_fixpt_converter.sv
// ---------------------------------------------------------------------------
// tb_inv_fixpt_converter
// Self-checking bench for inv_fixpt_converter. Element vectors live in
// tables; expected results are queued when a matrix is started and
// compared as the converter hands each result over.
// Honours INV_FIXPT_ROUND_EN for the rounded expectations and timing.
// ---------------------------------------------------------------------------
module tb_inv_fixpt_converter;

    localparam int ELEMS = 25;
`ifdef INV_FIXPT_ROUND_EN
    localparam int          PER   = 52;
    localparam logic [31:0] Q_2_3 = 32'h0000_AAAB;
    localparam logic [31:0] QN2_3 = 32'hFFFF_5555;
    localparam logic [31:0] Q_1_6 = 32'h0000_2AAB;
    localparam logic [31:0] QN1_6 = 32'hFFFF_D555;
`else
    localparam int          PER   = 51;
    localparam logic [31:0] Q_2_3 = 32'h0000_AAAA;
    localparam logic [31:0] QN2_3 = 32'hFFFF_5556;
    localparam logic [31:0] Q_1_6 = 32'h0000_2AAA;
    localparam logic [31:0] QN1_6 = 32'hFFFF_D556;
`endif

    typedef struct packed {
        logic [31:0] num;
        logic [31:0] den;
        logic [31:0] expQ;
        logic        expDz;
        logic        expSat;
    } vec_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] q;
        logic        dz;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        q_ready = 1'b1;
    logic [4:0]  elem_idx;
    logic [31:0] num_in;
    logic [31:0] den_in;
    logic [31:0] q_out;
    logic [4:0]  q_idx;
    logic        q_valid;
    logic        busy;
    logic        done;
    logic        dz_flag;
    logic        sat_flag;

    vec_t vecA[ELEMS];
    vec_t vecB[ELEMS];
    vec_t cur[ELEMS];
    exp_t sbQ[$];
    exp_t monExp;
    bit   monEn = 1'b0;

    int passCount = 0;
    int checkCount = 0;

    inv_fixpt_converter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .elem_idx (elem_idx),
        .num_in   (num_in),
        .den_in   (den_in),
        .q_out    (q_out),
        .q_idx    (q_idx),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .busy     (busy),
        .done     (done),
        .dz_flag  (dz_flag),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    // Upstream mux model: presents the pair addressed by elem_idx.
    assign num_in = cur[elem_idx].num;
    assign den_in = cur[elem_idx].den;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every handshake pops one expected result.
    always @(negedge clk) begin
        if (monEn && q_valid && q_ready) begin
            if (sbQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected result: idx %0d value 0x%08h, expected no output", q_idx, q_out);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput($sformatf("q_out[%0d]", monExp.idx), q_out, monExp.q);
                checkOutput($sformatf("q_idx[%0d]", monExp.idx), 32'(q_idx), 32'(monExp.idx));
                checkOutput($sformatf("dz_flag[%0d]", monExp.idx), 32'(dz_flag), 32'(monExp.dz));
                checkOutput($sformatf("sat_flag[%0d]", monExp.idx), 32'(sat_flag), 32'(monExp.sat));
            end
        end
    end

    // Selects a table, queues its expected results and pulses start.
    // Returns #1 after the edge that samples start.
    task automatic applyStimulus(input int which);
        if (which == 0) begin
            cur = vecA;
        end else begin
            cur = vecB;
        end
        for (int i = 0; i < ELEMS; i++) begin
            sbQ.push_back('{idx: 5'(i), q: cur[i].expQ, dz: cur[i].expDz, sat: cur[i].expSat});
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic runMatrix(input int which, input int bpIdx, input int bpCycles, input int expCycles);
        int  cycles;
        int  bpLeft;
        bit  gotDone;
        bit  bpActive;
        bit  bpUsed;
        cycles   = 0;
        bpLeft   = 0;
        gotDone  = 1'b0;
        bpActive = 1'b0;
        bpUsed   = 1'b0;
        applyStimulus(which);
        checkOutput("busy after start", 32'(busy), 32'd1);
        checkOutput("dz_flag cleared by start", 32'(dz_flag), 32'd0);
        checkOutput("sat_flag cleared by start", 32'(sat_flag), 32'd0);
        checkOutput("elem_idx after start", 32'(elem_idx), 32'd0);
        while (!gotDone && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
            // A start while busy must be ignored.
            if (cycles == 100) start = 1'b1;
            if (cycles == 101) start = 1'b0;
            if (done) begin
                gotDone = 1'b1;
            end else if (bpActive) begin
                checkOutput("q_out held", q_out, cur[bpIdx].expQ);
                checkOutput("q_idx held", 32'(q_idx), 32'(bpIdx));
                checkOutput("elem_idx held", 32'(elem_idx), 32'(bpIdx));
                checkOutput("q_valid held", 32'(q_valid), 32'd1);
                bpLeft--;
                if (bpLeft == 0) begin
                    q_ready  = 1'b1;
                    bpActive = 1'b0;
                    bpUsed   = 1'b1;
                end
            end else if (!bpUsed && bpIdx >= 0 && q_valid && (32'(q_idx) == 32'(bpIdx))) begin
                q_ready  = 1'b0;
                bpActive = 1'b1;
                bpLeft   = bpCycles;
            end
        end
        if (!gotDone) begin
            checkCount++;
            $display("[TB] FAIL done timeout: no done after %0d cycles, expected done after %0d", cycles, expCycles);
            q_ready = 1'b1;
        end else begin
            checkOutput("run length", 32'(cycles), 32'(expCycles));
            checkOutput("final dz_flag", 32'(dz_flag), 32'(cur[ELEMS-1].expDz));
            checkOutput("final sat_flag", 32'(sat_flag), 32'(cur[ELEMS-1].expSat));
            @(posedge clk);
            #1;
            checkOutput("done one cycle", 32'(done), 32'd0);
            checkOutput("idle after done", 32'(busy), 32'd0);
            checkOutput("elem_idx back to 0", 32'(elem_idx), 32'd0);
        end
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
        sbQ.delete();
    endtask

    task automatic resetMidDiv();
        int cycles;
        int doneSeen;
        cycles   = 0;
        doneSeen = 0;
        applyStimulus(0);
        while (elem_idx != 5'd7 && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("reached index 7", 32'(elem_idx), 32'd7);
        // One FETCH cycle, then well inside DIV.
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2 reset = 1'b0;
        #1;
        monEn = 1'b0;
        checkOutput("mid-div reset q_valid", 32'(q_valid), 32'd0);
        checkOutput("mid-div reset busy", 32'(busy), 32'd0);
        checkOutput("mid-div reset done", 32'(done), 32'd0);
        checkOutput("mid-div reset elem_idx", 32'(elem_idx), 32'd0);
        checkOutput("mid-div reset q_out", q_out, 32'd0);
        checkOutput("mid-div reset q_idx", 32'(q_idx), 32'd0);
        sbQ.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("no done after reset", 32'(doneSeen), 32'd0);
        checkOutput("idle after reset", 32'(busy), 32'd0);
        monEn = 1'b1;
        runMatrix(0, -1, 0, ELEMS * PER);
    endtask

    initial begin
        for (int i = 0; i < ELEMS; i++) begin
            vecA[i] = '{32'd2, 32'd3, Q_2_3, 1'b0, 1'b0};
        end
        vecB[0]  = '{32'hFFFF_FFF9, 32'd2,         32'hFFFC_8000, 1'b0, 1'b0};
        vecB[1]  = '{32'd5,         32'hFFFF_FFFF, 32'hFFFB_0000, 1'b0, 1'b0};
        vecB[2]  = '{32'd0,         32'hFFFF_FFF7, 32'h0000_0000, 1'b0, 1'b0};
        vecB[3]  = '{32'd2,         32'd3,         Q_2_3,         1'b0, 1'b0};
        vecB[4]  = '{32'd1,         32'd0,         32'h7FFF_FFFF, 1'b1, 1'b0};
        vecB[5]  = '{32'hFFFF_8000, 32'd1,         32'h8000_0000, 1'b1, 1'b0};
        vecB[6]  = '{32'h4000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b1};
        vecB[7]  = '{32'hFFFF_FFFE, 32'd3,         QN2_3,         1'b1, 1'b1};
        vecB[8]  = '{32'd1,         32'd1,         32'h0001_0000, 1'b1, 1'b1};
        vecB[9]  = '{32'h0000_7FFF, 32'd1,         32'h7FFF_0000, 1'b1, 1'b1};
        vecB[10] = '{32'hFFFF_7FFF, 32'd1,         32'h8000_0000, 1'b1, 1'b1};
        vecB[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecB[12] = '{32'd1,         32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};
        vecB[13] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecB[14] = '{32'd1,         32'd3,         32'h0000_5555, 1'b1, 1'b1};
        vecB[15] = '{32'd1,         32'd6,         Q_1_6,         1'b1, 1'b1};
        vecB[16] = '{32'hFFFF_FFFF, 32'd6,         QN1_6,         1'b1, 1'b1};
        for (int i = 17; i < ELEMS; i++) begin
            vecB[i] = '{32'd3, 32'd4, 32'h0000_C000, 1'b1, 1'b1};
        end
        cur = vecA;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset q_valid", 32'(q_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset elem_idx", 32'(elem_idx), 32'd0);
        checkOutput("reset q_out", q_out, 32'd0);
        checkOutput("reset q_idx", 32'(q_idx), 32'd0);
        checkOutput("reset dz_flag", 32'(dz_flag), 32'd0);
        checkOutput("reset sat_flag", 32'(sat_flag), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle after reset release", 32'(busy), 32'd0);
        monEn = 1'b1;

        $display("[TB] matrix of 2/3");
        runMatrix(0, -1, 0, ELEMS * PER);
        $display("[TB] mixed matrix with backpressure at index 3");
        runMatrix(1, 3, 10, (ELEMS - 1) * PER + 3 + 10);
        $display("[TB] matrix of 2/3 after flags were set");
        runMatrix(0, -1, 0, ELEMS * PER);
        $display("[TB] reset during divide at index 7");
        resetMidDiv();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/inv_fixpt_converter.md
# inv_fixpt_converter

Sequential converter downstream of the 5x5 matrix inverter. It walks the inverter's 25 rational results (numerator/denominator pairs, row-major index 0..24) and divides each numerator by its denominator into signed Q16.16 fixed point, one element at a time. Results leave on a valid/ready stream toward the result RAM/readback logic. A thin combinational mux in the parent selects the `iRC`/`iRCd` pair addressed by `elem_idx`.

## Interface
- `FRAC_BITS`, 16: fractional bits of the output; the divider runs 32+FRAC_BITS iterations.
- `ELEMS`, 25: elements per matrix; the last index is ELEMS-1.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to convert a matrix; sampled only in IDLE.
- `elem_idx`  out  5  index of the pair being fetched (0..24).
- `num_in`  in  32  signed two's-complement numerator for `elem_idx`, valid in the same cycle.
- `den_in`  in  32  signed two's-complement denominator for `elem_idx`.
- `q_out`  out  32  signed Q16.16 result.
- `q_idx`  out  5  index of `q_out`.
- `q_valid`  out  1  result available.
- `q_ready`  in  1  consumer accepts; handshake = `q_valid & q_ready` at the edge.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last handshake.
- `dz_flag`  out  1  sticky: some denominator was zero. Cleared on `start` or reset.
- `sat_flag`  out  1  sticky: some result saturated. Cleared on `start` or reset.

## Operation
- FSM states: IDLE, FETCH, DIV, FIX, OUT, FIN.
- IDLE: when `start`=1, clear `elem_idx`, `dz_flag` and `sat_flag`, then go to FETCH.
- FETCH (1 cycle):
  - latch the signs of `num_in`/`den_in` and their magnitudes (32-bit unsigned, so -2^31 maps to 2^31);
  - set the dividend to |num| << FRAC_BITS (48 bits);
  - if `den_in`==0, set `dz_flag` and jump to FIX with the quotient forced to 0x7FFF_FFFF;
  - otherwise go to DIV.
- DIV: restoring unsigned division, one quotient bit per cycle, MSB first, 32+FRAC_BITS cycles, counted by a 6-bit iteration counter.
- FIX (1 cycle):
  - the result is negative iff the input signs differ and the quotient magnitude is non-zero;
  - a magnitude above 0x7FFF_FFFF (positive), or above 0x8000_0000 (negative), saturates to 0x7FFF_FFFF or 0x8000_0000 and sets `sat_flag`;
  - a negative result with magnitude exactly 0x8000_0000 is exact and does not set `sat_flag`;
  - otherwise negate as two's complement when negative;
  - the result register loads `q_out` and `q_idx`; go to OUT.
- Rounding: truncation toward zero (see Configuration for the alternative).
- OUT: hold `q_valid`=1 with `q_out`/`q_idx` stable until the handshake. After it: if `elem_idx`==ELEMS-1, go to FIN; otherwise increment `elem_idx` and go to FETCH.
- FIN: pulse `done` for one cycle, then go to IDLE. `elem_idx` returns to 0.
- `start` outside IDLE is ignored.
- Reset asserted in any state, including mid-DIV:
  - immediately returns to IDLE;
  - clears all registers;
  - discards the partial matrix with no `done`.
- Reset values: `elem_idx`=0, `q_out`=0, `q_idx`=0, `q_valid`=0, `busy`=0, `done`=0, `dz_flag`=0, `sat_flag`=0.

## Timing
- `start` is sampled at edge T. FETCH occupies T+1, DIV occupies T+2..T+49, FIX occupies T+50, and `q_valid` rises in T+51.
- Per element with `q_ready` held high: 51 cycles, i.e. FETCH, 48 DIV, FIX, OUT.
- A zero denominator skips DIV, giving 3 cycles for that element.
- Full matrix with `q_ready`=1 and no zero denominators: 25×51 cycles. `done` is high in the cycle after the final handshake.
- Backpressure: each cycle with `q_ready`=0 in OUT adds one cycle; nothing advances meanwhile.
- `elem_idx` changes only on the exit edge of OUT, so the upstream mux has one full cycle to settle before FETCH samples.

## Configuration
- `INV_FIXPT_ROUND_EN`
  - Defined: DIV runs one extra iteration (33+FRAC_BITS cycles; 52 cycles per element). FIX adds the extra LSB to the magnitude before the shift-down, giving round-half-away-from-zero. The saturation check is applied after rounding.
  - Undefined: truncation toward zero, timing as specified above.

## Structure
- Package `inv_pkg`:
  - FSM state enum;
  - `FRAC_BITS` default;
  - constants `Q_POS_MAX`=32'h7FFF_FFFF and `Q_NEG_MAX`=32'h8000_0000;
  - index width 5.
- Sub-module `div_seq_unsigned`: restoring divider with load/step/done, 48-bit dividend, 32-bit divisor, iteration count as a parameter. Top level: FSM, sign handling, saturation, stream output.

## Test plan
- All pairs num=2, den=3, `q_ready`=1 → 25 results of 0x0000_AAAA (0x0000_AAAB with `INV_FIXPT_ROUND_EN`), `q_idx` 0..24 in order, `done` one cycle after the last handshake.
- num=-7, den=2 → 0xFFFC_8000; num=5, den=-1 → 0xFFFB_0000; num=0, den=-9 → 0x0000_0000.
- den=0 at index 4 → `q_out`=0x7FFF_FFFF for that element, `dz_flag`=1 until the next `start`, element latency 3 cycles.
- num=0x4000_0000, den=1 → 0x7FFF_FFFF with `sat_flag`=1; num=-32768, den=1 → 0x8000_0000 with `sat_flag`=0.
- `q_ready` low for 10 cycles at index 3 → `q_out`/`q_idx` stable, `elem_idx` held at 3, total run exactly 10 cycles longer.
- Reset asserted mid-DIV at index 7 → all outputs 0 immediately, no `done`; a following `start` restarts from index 0 with the full expected sequence.
